// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-channel byte-serial memory arbiter with load sign-extension and IO back-pressure.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with channel 0 highest.
module mem_arbiter #(
  parameter int          NUM_CH  = 3,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  input  logic                  io_buffer_full,
  output logic [31:0]           mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     we,
  input  logic [2*NUM_CH-1:0]   size,
  input  logic [NUM_CH-1:0]     sext,
  input  logic [32*NUM_CH-1:0]  addr,
  input  logic [32*NUM_CH-1:0]  wdata,
  output logic [NUM_CH-1:0]     done,
  output logic [31:0]           rdata
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      gnt, gnt_nxt, pick;
  logic               we_l, we_l_nxt, sext_l, sext_l_nxt;
  logic [2:0]         nbytes, nbytes_nxt, cnt, cnt_nxt;
  logic [31:0]        addr_l, addr_l_nxt, wdata_l, wdata_l_nxt, ld_buf, ld_buf_nxt;
  logic [31:0]        mem_a_nxt, rdata_nxt;
  logic [7:0]         mem_dout_nxt;
  logic               mem_wr_nxt;
  logic [NUM_CH-1:0]  done_nxt;
  logic [1:0]         size_a  [NUM_CH];
  logic [31:0]        addr_a  [NUM_CH];
  logic [31:0]        wdata_a [NUM_CH];
  logic [1:0]         byte_idx;
  logic               io_stall;

  // Widen a partially loaded little-endian value to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] n, input logic sx);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{sx & b[7]}}, b[7:0]};
      3'd2:    r = {{16{sx & b[15]}}, b[15:0]};
      default: r = b;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      size_a[i]  = size[2*i +: 2];
      addr_a[i]  = addr[32*i +: 32];
      wdata_a[i] = wdata[32*i +: 32];
    end
  end

`ifdef MEM_ARB_RR_EN
  logic [CW-1:0] rr_ptr, rr_idx;
  logic          rr_found;

  // Search starts at the channel after the last grant and wraps at NUM_CH.
  always_comb begin
    pick     = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rr_ptr) + i >= NUM_CH) rr_idx = CW'(int'(rr_ptr) + i - NUM_CH);
      else                            rr_idx = CW'(int'(rr_ptr) + i);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        pick     = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                 rr_ptr <= '0;
    else if (rdy && state == IDLE && |req)   rr_ptr <= (pick == CW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) pick = CW'(i);
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    we_l_nxt     = we_l;
    sext_l_nxt   = sext_l;
    nbytes_nxt   = nbytes;
    cnt_nxt      = cnt;
    addr_l_nxt   = addr_l;
    wdata_l_nxt  = wdata_l;
    ld_buf_nxt   = ld_buf;
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    mem_wr_nxt   = mem_wr;
    rdata_nxt    = rdata;
    done_nxt     = '0;
    byte_idx     = cnt[1:0] - 2'd1;
    // A store byte at or above IO_BASE waits while the IO sink is full.
    io_stall     = we_l && io_buffer_full && (mem_a >= IO_BASE);
    case (state)
      IDLE: begin
        mem_a_nxt  = 32'd0;
        mem_wr_nxt = 1'b0;
        if (|req) begin
          gnt_nxt     = pick;
          we_l_nxt    = we[pick];
          sext_l_nxt  = sext[pick];
          addr_l_nxt  = addr_a[pick];
          wdata_l_nxt = wdata_a[pick];
          case (size_a[pick])
            2'd0:    nbytes_nxt = 3'd1;
            2'd1:    nbytes_nxt = 3'd2;
            default: nbytes_nxt = 3'd4;
          endcase
          cnt_nxt    = 3'd1;
          ld_buf_nxt = 32'd0;
          mem_a_nxt  = addr_a[pick];
          mem_wr_nxt = we[pick];
          if (we[pick]) mem_dout_nxt = wdata_a[pick][7:0];
          else          mem_dout_nxt = mem_dout;
          state_nxt  = XFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (!we_l) begin
          ld_buf_nxt[{byte_idx, 3'b000} +: 8] = mem_din;
          if (cnt == nbytes) begin
            rdata_nxt     = extend(ld_buf_nxt, nbytes, sext_l);
            done_nxt[gnt] = 1'b1;
            mem_a_nxt     = 32'd0;
            state_nxt     = DONE;
          end else begin
            mem_a_nxt = addr_l + {29'd0, cnt};
            cnt_nxt   = cnt + 3'd1;
          end
        end else if (io_stall) begin
          state_nxt = XFER;
        end else if (cnt == nbytes) begin
          mem_wr_nxt    = 1'b0;
          mem_a_nxt     = 32'd0;
          done_nxt[gnt] = 1'b1;
          state_nxt     = DONE;
        end else begin
          mem_a_nxt    = addr_l + {29'd0, cnt};
          mem_dout_nxt = wdata_l[{cnt[1:0], 3'b000} +: 8];
          cnt_nxt      = cnt + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      we_l     <= 1'b0;
      sext_l   <= 1'b0;
      nbytes   <= 3'd1;
      cnt      <= 3'd0;
      addr_l   <= 32'd0;
      wdata_l  <= 32'd0;
      ld_buf   <= 32'd0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      rdata    <= 32'd0;
      done     <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      we_l     <= we_l_nxt;
      sext_l   <= sext_l_nxt;
      nbytes   <= nbytes_nxt;
      cnt      <= cnt_nxt;
      addr_l   <= addr_l_nxt;
      wdata_l  <= wdata_l_nxt;
      ld_buf   <= ld_buf_nxt;
      mem_a    <= mem_a_nxt;
      mem_dout <= mem_dout_nxt;
      mem_wr   <= mem_wr_nxt;
      rdata    <= rdata_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_arbiter;
  localparam int          NUM_CH  = 3;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rdy = 1'b1;
  logic [7:0]           mem_din;
  logic                 io_buffer_full = 1'b0;
  logic [31:0]          mem_a;
  logic [7:0]           mem_dout;
  logic                 mem_wr;
  logic [NUM_CH-1:0]    req = '0;
  logic [NUM_CH-1:0]    we = '0;
  logic [2*NUM_CH-1:0]  size = '0;
  logic [NUM_CH-1:0]    sext = '0;
  logic [32*NUM_CH-1:0] addr = '0;
  logic [32*NUM_CH-1:0] wdata = '0;
  logic [NUM_CH-1:0]    done;
  logic [31:0]          rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tr_a [64];
  logic [7:0]  tr_d [64];

  mem_arbiter #(.NUM_CH(NUM_CH), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .req(req), .we(we), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .done(done), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h200: return 8'h80;
      32'h300: return 8'h34;
      32'h301: return 8'hA7;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign mem_din = ram_rd(mem_a);

  // Value a load must return, computed arithmetically from the RAM contents.
  function automatic logic [31:0] load_value(input logic [31:0] a, input int n, input logic sx);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(ram_rd(a + 32'(k))) << (8 * k);
    if (sx && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare.
  initial begin
    int ph, m_ch, m_n, m_k, rr, sel, sz;
    logic m_we, m_sx;
    logic [31:0] m_addr, m_wd, e_a;
    logic e_wr;
    logic [7:0] e_dout;
    logic [NUM_CH-1:0] e_done, s_req;
    logic s_rst, s_rdy, s_full;
    ph = 0; rr = 0; m_ch = 0; m_n = 1; m_k = 0; m_we = 0; m_sx = 0;
    m_addr = 0; m_wd = 0; e_a = 0; e_wr = 0; e_dout = 0; e_done = 0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_rdy = rdy; s_req = req; s_full = io_buffer_full;
      if (s_rst) begin
        ph = 0; rr = 0; e_a = 0; e_wr = 0; e_done = 0;
      end else if (s_rdy) begin
        e_done = 0;
        if (ph == 0) begin
          if (|s_req) begin
            sel = -1;
`ifdef MEM_ARB_RR_EN
            for (int i = 0; i < NUM_CH; i++)
              if (sel < 0 && s_req[(rr + i) % NUM_CH]) sel = (rr + i) % NUM_CH;
            rr = (sel + 1) % NUM_CH;
`else
            for (int i = 0; i < NUM_CH; i++) if (sel < 0 && s_req[i]) sel = i;
`endif
            m_ch = sel; m_we = we[sel]; m_sx = sext[sel];
            m_addr = addr[32*sel +: 32]; m_wd = wdata[32*sel +: 32];
            sz = int'(size[2*sel +: 2]);
            m_n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            m_k = 0; e_a = m_addr; e_wr = m_we; e_dout = m_wd[7:0]; ph = 1;
          end else begin
            e_a = 0; e_wr = 0;
          end
        end else if (ph == 1) begin
          if (!(m_we && s_full && (m_addr + 32'(m_k)) >= IO_BASE)) begin
            m_k++;
            if (m_k == m_n) begin
              e_done[m_ch] = 1'b1; e_a = 0; e_wr = 0; ph = 2;
            end else begin
              e_a = m_addr + 32'(m_k);
              e_dout = 8'((m_wd >> (8 * m_k)) & 32'hFF);
            end
          end
        end else begin
          ph = 0;
        end
      end
      #1;
      check("model mem_a", mem_a, e_a);
      check("model mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
      check("model done", {29'd0, done}, {29'd0, e_done});
      if (e_wr) check("model mem_dout", {24'd0, mem_dout}, {24'd0, e_dout});
      if (s_rst) begin
        check("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        check("reset rdata", rdata, 32'd0);
      end
      if (|e_done && !m_we && s_rdy && !s_rst) check("model rdata", rdata, load_value(m_addr, m_n, m_sx));
    end
  end

  task automatic apply(input int kind, input int st, input int len, input int c);
    logic on;
    on = (c >= st) && (c < st + len);
    rdy = !(kind == 1 && on);
    io_buffer_full = (kind == 2 && on);
    rst = (kind == 3 && on);
  endtask

  // kind: 0 none, 1 rdy low, 2 io_buffer_full high, 3 reset; window covers edges E_st..E_(st+len-1).
  task automatic run(input int ch, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] ad, input logic [31:0] wd, input int kind, input int st,
                     input int len, output int lat, output logic [31:0] rd);
    @(negedge clk);
    addr[32*ch +: 32] = ad; wdata[32*ch +: 32] = wd; we[ch] = w;
    size[2*ch +: 2] = sz; sext[ch] = sx; req[ch] = 1'b1;
    apply(kind, st, len, 0);
    lat = -1; rd = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      tr_a[c] = mem_a; tr_d[c] = mem_dout;
      if (kind == 3 && c == st + 1) begin
        check("rst mid-store mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst mid-store done", {29'd0, done}, 32'd0);
        check("rst mid-store mem_a", mem_a, 32'd0);
        lat = c;
        break;
      end
      if (|done) begin
        lat = c; rd = rdata;
        break;
      end
      @(negedge clk);
      if (c == 1) begin
        addr[32*ch +: 32] = ~ad; wdata[32*ch +: 32] = ~wd; we[ch] = ~w;
        size[2*ch +: 2] = sz ^ 2'b01; sext[ch] = ~sx;
      end
      apply(kind, st, len, c);
    end
    if (lat < 0) check("transfer timeout", 32'd0, 32'd1);
    @(negedge clk);
    req = '0; rdy = 1'b1; io_buffer_full = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int lat, got_n;
    logic [31:0] rd;
    int got [4];
    int exp_ord [4];
    repeat (3) @(negedge clk);
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset done", {29'd0, done}, 32'd0);
    check("reset rdata lit", rdata, 32'd0);
    rst = 1'b0;

    run(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0, 0, 0, lat, rd);
    check("ch1 load4 latency", 32'(lat), 32'd5);
    check("ch1 load4 rdata", rd, 32'h44332211);
    check("ch1 load4 addr E1", tr_a[2], 32'h101);
    check("ch1 load4 addr E3", tr_a[4], 32'h103);

    run(0, 1'b0, 2'd0, 1'b1, 32'h200, 32'd0, 0, 0, 0, lat, rd);
    check("load1 sext latency", 32'(lat), 32'd2);
    check("load1 sext rdata", rd, 32'hFFFFFF80);
    rdy = 1'b0;
    @(posedge clk); #1;
    check("rdy low holds done", {29'd0, done}, 32'd1);
    @(negedge clk); rdy = 1'b1;

    run(0, 1'b0, 2'd0, 1'b0, 32'h200, 32'd0, 0, 0, 0, lat, rd);
    check("load1 zext rdata", rd, 32'h00000080);

    run(2, 1'b0, 2'd1, 1'b1, 32'h300, 32'd0, 0, 0, 0, lat, rd);
    check("load2 sext latency", 32'(lat), 32'd3);
    check("load2 sext rdata", rd, 32'hFFFFA734);

    run(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 0, 0, 0, lat, rd);
    check("size3 as 4 bytes", rd, 32'h44332211);

    run(1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0, 0, 0, 0, lat, rd);
    check("wrap load addr", tr_a[3], 32'h0);
    check("wrap load rdata", rd, 32'h5B5AA5A4);

    run(2, 1'b1, 2'd1, 1'b0, 32'h30000, 32'h0000BEEF, 2, 1, 3, lat, rd);
    check("io stall latency", 32'(lat), 32'd6);
    check("io stall held addr", tr_a[4], 32'h30000);
    check("io stall held byte", {24'd0, tr_d[4]}, 32'hEF);
    check("io stall 2nd addr", tr_a[5], 32'h30001);
    check("io stall 2nd byte", {24'd0, tr_d[5]}, 32'hBE);

    run(0, 1'b1, 2'd2, 1'b0, 32'h2FFFE, 32'hDDCCBBAA, 2, 1, 3, lat, rd);
    check("io boundary latency", 32'(lat), 32'd6);

    run(1, 1'b1, 2'd1, 1'b0, 32'h1000, 32'h0000A55A, 2, 1, 5, lat, rd);
    check("non-io store ignores full", 32'(lat), 32'd3);

    run(1, 1'b0, 2'd0, 1'b0, 32'h30000, 32'd0, 2, 1, 3, lat, rd);
    check("io load ignores full", 32'(lat), 32'd2);
    check("io load rdata", rd, 32'h5A);

    run(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1, 2, 2, lat, rd);
    check("rdy low load latency", 32'(lat), 32'd7);
    check("rdy low load rdata", rd, 32'h44332211);

    run(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 3, 2, 1, lat, rd);
    repeat (4) @(negedge clk);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      we[i] = 1'b0; size[2*i +: 2] = 2'd0; sext[i] = 1'b0;
      addr[32*i +: 32] = 32'h100 + 32'(i);
    end
    req = 3'b111;
    got_n = 0;
    for (int c = 0; c < 60 && got_n < 4; c++) begin
      @(posedge clk); #1;
      if (|done) begin
        for (int i = 0; i < NUM_CH; i++) if (done[i]) got[got_n] = i;
        got_n++;
      end
    end
    @(negedge clk); req = '0;
    check("arb grant count", 32'(got_n), 32'd4);
`ifdef MEM_ARB_RR_EN
    exp_ord = '{0, 1, 2, 0};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < got_n; i++) check($sformatf("arb order %0d", i), 32'(got[i]), 32'(exp_ord[i]));
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of requester channels (legal 1..8); channel 0 is highest fixed priority.
REQ-002 Parameter IO_BASE, default 32'h0003_0000, lowest address of the memory-mapped IO window.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; when low, all state and outputs hold.
REQ-006 mem_din  in  8  RAM read byte, valid one cycle after its address is driven.
REQ-007 io_buffer_full  in  1  IO sink cannot accept a byte.
REQ-008 mem_a  out  32  RAM byte address (registered).
REQ-009 mem_dout  out  8  RAM write byte (registered).
REQ-010 mem_wr  out  1  1 = write, 0 = read (registered).
REQ-011 req  in  NUM_CH  per-channel request; held high until that channel's done.
REQ-012 we  in  NUM_CH  per-channel 1 = store, 0 = load.
REQ-013 size  in  2*NUM_CH  per-channel access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal.
REQ-014 sext  in  NUM_CH  per-channel sign-extend enable for loads narrower than 4 bytes.
REQ-015 addr  in  32*NUM_CH  per-channel start byte address.
REQ-016 wdata  in  32*NUM_CH  per-channel store data, little-endian.
REQ-017 done  out  NUM_CH  one-cycle completion pulse, one-hot.
REQ-018 rdata  out  32  load result; valid in the cycle done is high.

Function
REQ-019 States: IDLE, XFER, DONE; encoding is free.
REQ-020 IDLE: with any req bit high, grant one channel per the arbitration policy and latch its we, size, sext, addr, wdata. Set byte count n = 1, 2 or 4. Go to XFER.
REQ-021 Only latched values are used after grant; later changes on the granted channel's inputs have no effect.
REQ-022 Load: at grant edge E0 and edges E1..E(n-1), drive mem_a = addr+k with mem_wr = 0. Sample mem_din at E1..En into rdata byte k-1.
REQ-023 Load finish: at edge En, fill rdata bits above the loaded bytes with the top loaded bit if sext = 1, else zeros. Assert done for the granted channel; go to DONE.
REQ-024 Store: at E0..E(n-1), drive mem_a = addr+k, mem_dout = wdata byte k, mem_wr = 1.
REQ-025 Store finish: at En, set mem_wr = 0, mem_a = 0, assert done; go to DONE.
REQ-026 DONE: clear done and return to IDLE. A new grant is possible no earlier than edge E(n+2).
REQ-027 IO stall: while a store byte's address is >= IO_BASE and io_buffer_full = 1, hold that byte and its address and do not advance. Loads and non-IO stores ignore io_buffer_full.
REQ-028 Address increment wraps modulo 2^32.
REQ-029 rdy low: freeze state, byte counter and all outputs, including done.
REQ-030 size = 3 is treated as size 2 (4 bytes).
REQ-031 req of a channel other than the granted one is ignored until the next IDLE arbitration.
REQ-032 In IDLE with no request: mem_wr = 0, mem_a = 0, done = 0.

Reset
REQ-033 rst high, including mid-transfer: state = IDLE, mem_wr = 0, mem_a = 0, mem_dout = 0, done = 0, rdata = 0, round-robin pointer = 0; any partial transfer is abandoned.
REQ-034 rst has priority over rdy.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: round-robin arbitration. Search starts at the channel after the last granted one and wraps at NUM_CH. The pointer updates on each grant.
REQ-036 Macro MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists.

Verification
REQ-037 Ch1 4-byte load at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; done[1] at E4; rdata = 0x44332211.
REQ-038 Ch0 1-byte load, sext = 1, byte 0x80 -> rdata = 0xFFFFFF80; with sext = 0 -> rdata = 0x00000080.
REQ-039 Ch2 2-byte store 0xBEEF to 0x30000 with io_buffer_full high for 3 cycles at the first byte -> byte 0xEF held on mem_a 0x30000 for 3 extra cycles, then 0xBE at 0x30001; done 3 cycles late.
REQ-040 req = 3'b111 held continuously -> fixed-priority build grants ch0 repeatedly; MEM_ARB_RR_EN build grants 0, 1, 2, 0 in order.
REQ-041 rst asserted at E2 of a 4-byte store -> the next cycle shows mem_wr = 0, done = 0, state IDLE; no further bytes are written.
REQ-042 rdy low for 2 cycles mid-load -> the transfer completes 2 cycles late with correct rdata.
